core_sequencer: RTL

Multi-cycle control sequencer for the 16-bit RISC datapath. It replaces the single-cycle decoder with a state machine that steps the datapath through fetch, decode, execute, memory and write-back. It stretches memory phases with a ready handshake and provides run/halt/single-step debug control. Its outputs drive the datapath's control inputs plus PC and instruction-register enables; it consumes the datapath's `opcode` output.

---
 rtl/core_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the 16-bit RISC datapath.
// Steps fetch/decode/execute/memory/write-back under run, step and halt control.
module core_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               halt_req,
    input  logic [3:0]         opcode,
    input  logic               mem_ready,
    output logic               ir_en,
    output logic               pc_en,
    output logic               jump,
    output logic               beq,
    output logic               bne,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic               reg_dst,
    output logic               reg_write,
    output logic [1:0]         alu_op,
    output logic               halted,
    output logic               trapped,
    output logic               illegal,
    output logic               bus_error,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    state_t             w_boundary;
    logic [3:0]         r_op;
    logic [3:0]         w_op;
    logic [7:0]         r_wait;
    logic               r_step;
    logic               r_illegal;
    logic               r_bus_err;
    logic [COUNT_W-1:0] r_count;
    logic               w_lw;
    logic               w_sw;
    logic               w_rtype;
    logic               w_beq;
    logic               w_bne;
    logic               w_jmp;
    logic               w_ill;
    logic               w_in_instr;
    logic               w_timeout;

    // op_q is not loaded until the end of DECODE, so DECODE looks at the live opcode
    assign w_op    = (r_state == S_DECODE) ? opcode : r_op;
    assign w_lw    = (w_op == 4'b0000);
    assign w_sw    = (w_op == 4'b0001);
    assign w_rtype = (w_op >= 4'b0010) && (w_op <= 4'b1001);
    assign w_beq   = (w_op == 4'b1011);
    assign w_bne   = (w_op == 4'b1100);
    assign w_jmp   = (w_op == 4'b1101);
    assign w_ill   = (w_op == 4'b1010) || (w_op >= 4'b1110);

    assign w_in_instr = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                        (r_state == S_MEM) || (r_state == S_WB);
    assign w_boundary = (run && !halt_req && !r_step) ? S_FETCH : S_IDLE;
    assign w_timeout  = (r_state == S_MEM) && !mem_ready &&
                        (r_wait == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        w_next     = r_state;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        jump       = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        if (w_in_instr) begin
            if (w_rtype) begin
                reg_dst = 1'b1;
                alu_op  = 2'b10;
            end
            if (w_lw || w_sw) alu_src = 1'b1;
            if (w_lw) mem_to_reg = 1'b1;
            if (w_beq || w_bne) alu_op = 2'b01;
        end
        unique case (r_state)
            S_IDLE: begin
                if ((run && !halt_req) || step) w_next = S_FETCH;
            end
            S_FETCH: begin
                ir_en  = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = w_ill ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else if (w_rtype) begin
                    w_next = S_WB;
                end else begin
                    beq    = w_beq;
                    bne    = w_bne;
                    jump   = w_jmp;
                    pc_en  = 1'b1;
                    w_next = w_boundary;
                end
            end
            S_MEM: begin
                mem_read  = w_lw;
                mem_write = w_sw;
                pc_en     = w_sw && mem_ready;
                if (mem_ready) w_next = w_lw ? S_WB : w_boundary;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_en     = 1'b1;
                w_next    = w_boundary;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 4'd0;
            r_wait    <= 8'd0;
            r_step    <= 1'b0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= opcode;
            r_wait <= (r_state == S_MEM) ? r_wait + 8'd1 : 8'd0;
            // run beats step when both start an instruction
            if (r_state == S_IDLE && w_next == S_FETCH)
                r_step <= !(run && !halt_req);
            if (r_state == S_DECODE && w_ill) r_illegal <= 1'b1;
            if (w_timeout) r_bus_err <= 1'b1;
            if (pc_en) r_count <= r_count + COUNT_W'(1);
        end
    end

    assign halted      = (r_state == S_IDLE);
    assign trapped     = (r_state == S_TRAP);
    assign illegal     = r_illegal;
    assign bus_error   = r_bus_err;
    assign instr_count = r_count;

endmodule
